// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial
// Brief    : Digit-serial 16-function logic/arithmetic ALU, D bits per clock,
//            LSB digit first, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial #(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         m,
    input  logic [3:0]   s,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);

    localparam int c_DS   = (D < 1) ? 1 : D;
    localparam int c_K    = N / c_DS;
    localparam int c_CW   = (c_K > 1) ? $clog2(c_K) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_K - 1);

    if ((D < 1) || (D > N) || ((N % c_DS) != 0)) begin : g_param_check
        $error("alu_serial: N must be a multiple of D with 1 <= D <= N");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic            r_m;
    logic [3:0]      r_s;
    logic [c_CW-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_out;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic [D-1:0]    w_ad;
    logic [D-1:0]    w_bd;
    logic [D-1:0]    w_x;
    logic [D-1:0]    w_y;
    logic [D-1:0]    w_logic;
    logic [D:0]      w_sum;
    logic [D-1:0]    w_res;
    logic [N-1:0]    w_a_next;
    logic [N-1:0]    w_b_next;

    // Only the lowest digit of each operand register is live; the rest shift down.
    always_comb begin
        w_ad    = r_a[D-1:0];
        w_bd    = r_b[D-1:0];
        w_logic = '0;
        w_x     = '0;
        w_y     = '0;
        case (r_s)
            4'd0:  begin w_logic = ~w_ad;          w_x = w_ad;          w_y = '1;            end
            4'd1:  begin w_logic = ~(w_ad & w_bd); w_x = w_ad & w_bd;   w_y = '1;            end
            4'd2:  begin w_logic = ~w_ad | w_bd;   w_x = w_ad & ~w_bd;  w_y = '1;            end
            4'd3:  begin w_logic = '1;             w_x = '1;            w_y = '0;            end
            4'd4:  begin w_logic = ~(w_ad | w_bd); w_x = w_ad;          w_y = w_ad | ~w_bd;  end
            4'd5:  begin w_logic = ~w_bd;          w_x = w_ad & w_bd;   w_y = w_ad | ~w_bd;  end
            4'd6:  begin w_logic = ~(w_ad ^ w_bd); w_x = w_ad;          w_y = ~w_bd;         end
            4'd7:  begin w_logic = w_ad | ~w_bd;   w_x = w_ad | ~w_bd;  w_y = '0;            end
            4'd8:  begin w_logic = ~w_ad & w_bd;   w_x = w_ad;          w_y = w_ad | w_bd;   end
            4'd9:  begin w_logic = w_ad ^ w_bd;    w_x = w_ad;          w_y = w_bd;          end
            4'd10: begin w_logic = w_bd;           w_x = w_ad & ~w_bd;  w_y = w_ad | w_bd;   end
            4'd11: begin w_logic = w_ad | w_bd;    w_x = w_ad | w_bd;   w_y = '0;            end
            4'd12: begin w_logic = '0;             w_x = w_ad;          w_y = w_ad;          end
            4'd13: begin w_logic = w_ad & ~w_bd;   w_x = w_ad & w_bd;   w_y = w_ad;          end
            4'd14: begin w_logic = w_ad & w_bd;    w_x = w_ad & ~w_bd;  w_y = w_ad;          end
            default: begin w_logic = w_ad;         w_x = w_ad;          w_y = '0;            end
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{D{1'b0}}, r_carry};
        w_res = r_m ? w_sum[D-1:0] : w_logic;
    end

    // Result digits enter at the top of r_a, so after K steps r_a holds the result.
    if (D == N) begin : g_single_digit
        assign w_a_next = w_res;
        assign w_b_next = r_b;
    end else begin : g_multi_digit
        assign w_a_next = {w_res, r_a[N-1:D]};
        assign w_b_next = {{D{1'b0}}, r_b[N-1:D]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_m     <= 1'b0;
            r_s     <= 4'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_m     <= m;
                        r_s     <= s;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_sum[D];
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_a_next;
                        r_cout  <= r_m & w_sum[D];
                        r_ovf   <= r_m & (w_x[D-1] == w_y[D-1]) & (w_sum[D-1] != w_x[D-1]);
                        r_zero  <= (w_a_next == '0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign out      = r_out;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial
// Brief    : Randomised self-checking bench for alu_serial at D=8, D=32, D=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        m;
    logic [3:0]  s;

    logic        busy8, done8, cout8, ovf8, zero8;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [31:0] out8, out32, out1;

    int n_vec;
    int n_err;

    alu_serial #(.N(32), .D(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .m(m), .s(s),
        .busy(busy8), .done(done8), .out(out8), .cout(cout8), .overflow(ovf8), .zero(zero8)
    );

    alu_serial #(.N(32), .D(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .m(m), .s(s),
        .busy(busy32), .done(done32), .out(out32), .cout(cout32), .overflow(ovf32), .zero(zero32)
    );

    alu_serial #(.N(32), .D(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .m(m), .s(s),
        .busy(busy1), .done(done1), .out(out1), .cout(cout1), .overflow(ovf1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: returns {zero, overflow, cout, out}.
    function automatic logic [34:0] ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rcin, input logic rm, input logic [3:0] rs);
        logic [31:0] x, y, r, ones;
        logic [32:0] sum;
        logic        co, ov;
        ones = 32'hFFFF_FFFF;
        x = '0; y = '0; r = '0; co = 1'b0; ov = 1'b0;
        if (!rm) begin
            case (rs)
                4'd0:  r = ~ra;
                4'd1:  r = ~(ra & rb);
                4'd2:  r = ~ra | rb;
                4'd3:  r = ones;
                4'd4:  r = ~(ra | rb);
                4'd5:  r = ~rb;
                4'd6:  r = ~(ra ^ rb);
                4'd7:  r = ra | ~rb;
                4'd8:  r = ~ra & rb;
                4'd9:  r = ra ^ rb;
                4'd10: r = rb;
                4'd11: r = ra | rb;
                4'd12: r = '0;
                4'd13: r = ra & ~rb;
                4'd14: r = ra & rb;
                default: r = ra;
            endcase
        end else begin
            case (rs)
                4'd0:  begin x = ra;       y = ones;     end
                4'd1:  begin x = ra & rb;  y = ones;     end
                4'd2:  begin x = ra & ~rb; y = ones;     end
                4'd3:  begin x = ones;     y = '0;       end
                4'd4:  begin x = ra;       y = ra | ~rb; end
                4'd5:  begin x = ra & rb;  y = ra | ~rb; end
                4'd6:  begin x = ra;       y = ~rb;      end
                4'd7:  begin x = ra | ~rb; y = '0;       end
                4'd8:  begin x = ra;       y = ra | rb;  end
                4'd9:  begin x = ra;       y = rb;       end
                4'd10: begin x = ra & ~rb; y = ra | rb;  end
                4'd11: begin x = ra | rb;  y = '0;       end
                4'd12: begin x = ra;       y = ra;       end
                4'd13: begin x = ra & rb;  y = ra;       end
                4'd14: begin x = ra & ~rb; y = ra;       end
                default: begin x = ra;     y = '0;       end
            endcase
            sum = 33'(x) + 33'(y) + 33'(rcin);
            r   = sum[31:0];
            co  = sum[32];
            ov  = (x[31] == y[31]) && (r[31] != x[31]);
        end
        return {(r == 32'd0), ov, co, r};
    endfunction

    // Applies one operation to all three instances, then scrambles the inputs.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2,
                          input logic tcin, input logic tm, input logic [3:0] ts);
        logic [34:0] e;
        int lat8, lat32, lat1, nd8, nd32, nd1;
        e = ref_op(ta, tb2, tcin, tm, ts);
        lat8 = 0; lat32 = 0; lat1 = 0; nd8 = 0; nd32 = 0; nd1 = 0;
        a = ta; b = tb2; cin = tcin; m = tm; s = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); m = 1'($urandom); s = 4'($urandom);
        check("busy_after_accept", {busy8, busy32, busy1}, 3'b111);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done8)  begin if (lat8 == 0)  lat8 = c;  nd8++;  end
            if (done32) begin if (lat32 == 0) lat32 = c; nd32++; end
            if (done1)  begin if (lat1 == 0)  lat1 = c;  nd1++;  end
        end
        check("lat_d8", lat8, 4);
        check("lat_d32", lat32, 1);
        check("lat_d1", lat1, 32);
        check("pulses_d8", nd8, 1);
        check("pulses_d32", nd32, 1);
        check("pulses_d1", nd1, 1);
        check("out_d8", out8, e[31:0]);
        check("out_d32", out32, e[31:0]);
        check("out_d1", out1, e[31:0]);
        check("flags_d8 {zero,ovf,cout}", {zero8, ovf8, cout8}, e[34:32]);
        check("flags_d32 {zero,ovf,cout}", {zero32, ovf32, cout32}, e[34:32]);
        check("flags_d1 {zero,ovf,cout}", {zero1, ovf1, cout1}, e[34:32]);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [34:0] e;
        int lat, nd;
        n_vec = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; m = 1'b0; s = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_done", {busy8, done8, busy32, done32, busy1, done1}, 6'd0);
        check("reset_out", out8, 32'd0);
        check("reset_flags", {cout8, ovf8, zero8}, 3'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'd9);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 4'd6);
        run_op(32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, 4'd15);
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 4'd6);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'd9);

        for (int i = 0; i < 25; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        // start pulses while busy must not disturb the operation in flight
        e = ref_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'd9);
        lat = 0; nd = 0;
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; m = 1'b1; s = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done8) begin if (lat == 0) lat = c; nd++; end
            if (c == 1 || c == 2) begin
                start = 1'b1; a = 32'h0; b = 32'h0; cin = 1'b1; m = 1'b0; s = 4'd12;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_start_lat", lat, 4);
        check("busy_start_pulses", nd, 1);
        check("busy_start_out", out8, e[31:0]);
        check("busy_start_flags", {zero8, ovf8, cout8}, e[34:32]);

        // reset two cycles into an operation aborts it silently
        nd = 0;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; m = 1'b1; s = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_out", out8, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        check("abort_no_done", nd, 0);

        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1, 4'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
